ysyx_24100013_mem_arbiter: RTL
==============================

YSYX_24100013_MEM_ARBITER -- requirements
Module: ysyx_24100013_mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, address width.
REQ-002 Parameter: DATA_W, 32, data width; mask width is DATA_W/8.
REQ-003 The module SHALL have one clock and an asynchronous, active-low reset, named as follows.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 ifu_req_valid / ifu_req_ready  in / out  1 / 1  IFU fetch request handshake.
REQ-007 ifu_addr  in  ADDR_W  fetch address (read only).
REQ-008 ifu_rsp_valid / ifu_rdata  out / out  1 / DATA_W  fetch response.
REQ-009 lsu_req_valid / lsu_req_ready  in / out  1 / 1  LSU request handshake.
REQ-010 lsu_addr, lsu_wen, lsu_wdata, lsu_wmask  in  ADDR_W, 1, DATA_W, DATA_W/8  load/store request.
REQ-011 lsu_rsp_valid / lsu_rdata  out / out  1 / DATA_W  load data or store acknowledge.
REQ-012 mem_req_valid / mem_req_ready  out / in  1 / 1  shared memory port request handshake.
REQ-013 mem_addr, mem_wen, mem_wdata, mem_wmask  out  ADDR_W, 1, DATA_W, DATA_W/8  registered request fields.
REQ-014 mem_rsp_valid / mem_rdata  in / in  1 / DATA_W  memory response.

Function
REQ-015 The FSM SHALL have states IDLE, REQ and WAIT; it allows one outstanding memory transaction.
REQ-016 IDLE: ifu_req_ready/lsu_req_ready SHALL depend only on state and the valid inputs, and be asserted only for the granted requester.
REQ-017 Arbitration SHALL be round-robin: on simultaneous valids, grant the requester not granted last; with only one valid, grant it.
REQ-018 On an accepted handshake, request fields SHALL be latched into mem_* registers, owner recorded, last-grant updated, and the state SHALL go IDLE->REQ.
REQ-019 For IFU grants, mem_wen=0 and mem_wmask=0 SHALL be driven.
REQ-020 REQ: mem_req_valid=1 and mem_* SHALL be held stable until mem_req_ready=1, then the state SHALL go REQ->WAIT.
REQ-021 WAIT: on mem_rsp_valid=1, the owner's rsp_valid SHALL assert in the same cycle with rdata=mem_rdata; the state SHALL go WAIT->IDLE.
REQ-022 The non-owner rsp_valid SHALL stay 0; mem_rsp_valid outside WAIT SHALL be ignored.
REQ-023 Both req_ready outputs SHALL be 0 in REQ and WAIT.
REQ-024 Minimum latency: accept at cycle N, mem_req_valid at N+1, earliest rsp at N+2, next accept at N+3.
REQ-025 A requester dropping valid before its handshake SHALL lose nothing; arbitration re-evaluates each IDLE cycle.

Reset
REQ-026 While rst=0: state=IDLE, last-grant=LSU (IFU wins the first tie), mem_req_valid=0, mem_wen=0, mem_addr/wdata/wmask=0, all ready and rsp_valid outputs=0.
REQ-027 Reset asserted mid-transaction SHALL abandon it immediately with no response, and after release the FSM SHALL restart in IDLE.

Structure
REQ-028 State encoding (IDLE/REQ/WAIT) and owner encoding (IFU/LSU) SHALL live in the shared ysyx_24100013 package.
REQ-029 Grant logic SHALL be one sub-module: ysyx_24100013_rr_arb2, a 2-way round-robin arbiter with inputs req[1:0] and last and output gnt[1:0].

Verification
REQ-030 Tie after reset: both valid, ifu_addr=0x80000000 and lsu_addr=0x80001000 -> IFU granted first, mem_addr=0x80000000, then LSU, mem_addr=0x80001000.
REQ-031 Backpressure: mem_req_ready low for 3 cycles -> mem_* held stable, and no requester ready until the response completes.
REQ-032 LSU store: lsu_wen=1, wdata=0xDEADBEEF, wmask=0xF -> mem_wen=1 with the same data and mask; lsu_rsp_valid pulses once and ifu_rsp_valid stays 0.
REQ-033 Response routing: IFU fetch with mem_rdata=0x00000513 -> ifu_rsp_valid=1 and ifu_rdata=0x00000513 for one cycle; lsu_rsp_valid=0.
REQ-034 Starvation: both valid continuously for 8 transactions -> grants alternate IFU, LSU, IFU, LSU...
REQ-035 Reset in WAIT: rst=0 for 1 cycle, then a late mem_rsp_valid -> no rsp_valid pulses, and the state is IDLE.

Source files
------------

// File: rtl/ysyx_24100013_pkg.sv
// Shared types for the ysyx_24100013 memory-side blocks: arbiter FSM states
// and transaction owner encoding.
package ysyx_24100013_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

endpackage

// File: rtl/ysyx_24100013_rr_arb2.sv
// Two-way round-robin grant: req[0]=IFU, req[1]=LSU; last names the
// requester granted most recently (owner_t encoding).
module ysyx_24100013_rr_arb2
  import ysyx_24100013_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // On a tie the side that did not win last time gets the grant.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last == OWN_LSU) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/ysyx_24100013_mem_arbiter.sv
// Shares one memory port between IFU and LSU with round-robin arbitration and
// a single outstanding transaction (IDLE -> REQ -> WAIT).
module ysyx_24100013_mem_arbiter
  import ysyx_24100013_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_rsp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,

  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_rsp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,

  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  arb_state_t state, state_nxt;
  owner_t     owner, last_gnt;
  logic [1:0] gnt;
  logic       ifu_acc, lsu_acc;

  ysyx_24100013_rr_arb2 u_rr_arb2 (
    .req  ({lsu_req_valid, ifu_req_valid}),
    .last (last_gnt),
    .gnt  (gnt)
  );

  assign ifu_acc   = ifu_req_valid & ifu_req_ready;
  assign lsu_acc   = lsu_req_valid & lsu_req_ready;
  assign ifu_rdata = mem_rdata;
  assign lsu_rdata = mem_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (ifu_acc || lsu_acc) state_nxt = ST_REQ;
      ST_REQ:  if (mem_req_ready)      state_nxt = ST_WAIT;
      ST_WAIT: if (mem_rsp_valid)      state_nxt = ST_IDLE;
      default:                         state_nxt = ST_IDLE;
    endcase
  end

  // Readies are gated by rst so nothing is offered while reset is held.
  always_comb begin
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    mem_req_valid = 1'b0;
    ifu_rsp_valid = 1'b0;
    lsu_rsp_valid = 1'b0;
    unique case (state)
      ST_IDLE: begin
        ifu_req_ready = rst & gnt[0];
        lsu_req_ready = rst & gnt[1];
      end
      ST_REQ:  mem_req_valid = 1'b1;
      ST_WAIT: begin
        ifu_rsp_valid = mem_rsp_valid & (owner == OWN_IFU);
        lsu_rsp_valid = mem_rsp_valid & (owner == OWN_LSU);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr  <= '0;
      mem_wen   <= 1'b0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      owner     <= OWN_IFU;
      last_gnt  <= OWN_LSU;
    end else if (ifu_acc) begin
      mem_addr  <= ifu_addr;
      mem_wen   <= 1'b0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      owner     <= OWN_IFU;
      last_gnt  <= OWN_IFU;
    end else if (lsu_acc) begin
      mem_addr  <= lsu_addr;
      mem_wen   <= lsu_wen;
      mem_wdata <= lsu_wdata;
      mem_wmask <= lsu_wmask;
      owner     <= OWN_LSU;
      last_gnt  <= OWN_LSU;
    end
  end

endmodule
